core_sequencer: RTL and testbench

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/core_pkg.sv | 26 ++
 rtl/core_sequencer_if.sv | 19 +
 rtl/pc_unit.sv | 34 +++
 rtl/core_sequencer.sv | 138 +++++++++++++
 tb/tb_core_sequencer.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the core sequencer: FSM state encoding,
// default widths, the halt opcode and a saturating counter helper.
package core_pkg;

  localparam int PC_W_DFLT = 10;
  localparam int OP_W_DFLT = 6;
  localparam logic [5:0] HALT_OP = 6'b111111;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Control bundle between the sequencer FSM and the program counter unit.
// The FSM state travels on this bundle, so it doubles as the debug view of the FSM.
interface core_sequencer_if #(
  parameter int PC_W = core_pkg::PC_W_DFLT
);
  import core_pkg::*;

  // Not a valid/ready handshake: the FSM drives state/start/take_br/target every
  // cycle and the pc unit acts on them at the next rising edge; pc is registered.
  state_e          state;
  logic            start;
  logic            take_br;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc;

  modport master (output state, output start, output take_br, output target, input pc);
  modport slave  (input state, input start, input take_br, input target, output pc);

endinterface

// File: rtl/pc_unit.sv
// Program counter register: cleared when a program starts, and at write-back it
// either takes the branch target or advances by one, wrapping at 2^PC_W.
module pc_unit #(
  parameter int PC_W = core_pkg::PC_W_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  core_sequencer_if.slave  bus
);
  import core_pkg::*;

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (bus.state == ST_WB) begin
      pc_d = bus.take_br ? bus.target : pc_q + PC_W'(1);
    end else if ((bus.state == ST_IDLE || bus.state == ST_HALT) && bus.start) begin
      pc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.pc = pc_q;

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, optional memory
// access and write-back over a shared memory, with busy/retired counters.
module core_sequencer #(
  parameter int              PC_W    = core_pkg::PC_W_DFLT,
  parameter int              OP_W    = core_pkg::OP_W_DFLT,
  parameter logic [OP_W-1:0] HALT_OP = core_pkg::HALT_OP
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [OP_W-1:0] opcode,
  input  logic            dec_mem_read,
  input  logic            dec_mem_write,
  input  logic            dec_branch,
  input  logic            dec_reg_write,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            mem_ready,
  output logic [PC_W-1:0] pc,
  output logic            mem_req,
  output logic            mem_we,
  output logic            mem_addr_sel,
  output logic            ir_we,
  output logic            reg_we,
  output logic            busy,
  output logic            Ack,
  output logic [15:0]     cycle_count,
  output logic [15:0]     instr_count
);
  import core_pkg::*;

  state_e      state_q;
  state_e      state_d;
  logic [15:0] cyc_q;
  logic [15:0] cyc_d;
  logic [15:0] ins_q;
  logic [15:0] ins_d;

  core_sequencer_if #(.PC_W(PC_W)) pc_bus ();

  assign pc_bus.state   = state_q;
  assign pc_bus.start   = Start;
  assign pc_bus.take_br = dec_branch & br_taken;
  assign pc_bus.target  = br_target;
  assign pc             = pc_bus.pc;

  pc_unit #(.PC_W(PC_W)) u_pc_unit (
    .clk (Clk),
    .rst (Reset),
    .bus (pc_bus.slave)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      ins_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      ins_q   <= ins_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    ins_d        = ins_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    reg_we       = 1'b0;
    busy         = 1'b0;
    Ack          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_FETCH;
          cyc_d   = '0;
          ins_d   = '0;
        end
      end
      ST_FETCH: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        busy    = 1'b1;
        state_d = (opcode == HALT_OP) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        busy    = 1'b1;
        state_d = (dec_mem_read | dec_mem_write) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        busy         = 1'b1;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = dec_mem_write;
        if (mem_ready) begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        busy    = 1'b1;
        // A store never writes the register file, even if the decoder flags it.
        reg_we  = dec_reg_write & ~dec_mem_write;
        ins_d   = sat_inc(ins_q);
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        Ack = 1'b1;
        if (Start) begin
          state_d = ST_FETCH;
          cyc_d   = '0;
          ins_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (busy) begin
      cyc_d = sat_inc(cyc_q);
    end
  end

  assign cycle_count = cyc_q;
  assign instr_count = ins_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: programs are modelled as instruction lists,
// expected events are queued at issue time and a monitor consumes them from the DUT.
module tb_core_sequencer;

  localparam logic [5:0] HALT = 6'b111111;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  logic        Start;
  logic [5:0]  opcode;
  logic        dec_mem_read, dec_mem_write, dec_branch, dec_reg_write;
  logic        br_taken;
  logic [9:0]  br_target;
  logic        mem_ready;
  logic [9:0]  pc;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, reg_we, busy, Ack;
  logic [15:0] cycle_count, instr_count;

  core_sequencer #(.PC_W(10), .OP_W(6), .HALT_OP(HALT)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Start         (Start),
    .opcode        (opcode),
    .dec_mem_read  (dec_mem_read),
    .dec_mem_write (dec_mem_write),
    .dec_branch    (dec_branch),
    .dec_reg_write (dec_reg_write),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .mem_ready     (mem_ready),
    .pc            (pc),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr_sel  (mem_addr_sel),
    .ir_we         (ir_we),
    .reg_we        (reg_we),
    .busy          (busy),
    .Ack           (Ack),
    .cycle_count   (cycle_count),
    .instr_count   (instr_count)
  );

  // ---------------- program representation ----------------
  typedef struct packed {
    logic [5:0] op;
    logic       rd;
    logic       wr;
    logic       br;
    logic       tk;
    logic       rw;
    logic [9:0] tgt;
    logic [3:0] fw;   // cycles mem_ready stays low before the fetch completes
    logic [3:0] mw;   // same for the data access
  } instr_t;

  instr_t prog[$];

  function automatic instr_t mk(input logic [5:0] op, input logic rd, input logic wr,
                                input logic br, input logic tk, input logic rw,
                                input logic [9:0] tgt, input logic [3:0] fw,
                                input logic [3:0] mw);
    instr_t t;
    t.op = op; t.rd = rd; t.wr = wr; t.br = br; t.tk = tk; t.rw = rw;
    t.tgt = tgt; t.fw = fw; t.mw = mw;
    return t;
  endfunction

  function automatic instr_t get_instr(input int i);
    if (i >= 0 && i < prog.size()) return prog[i];
    return mk(HALT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 4'd0, 4'd0);
  endfunction

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  logic [13:0] exp_fetch_q[$];  // {pc, fetch wait}
  logic [4:0]  exp_mem_q[$];    // {mem_we, data wait}
  logic [9:0]  exp_reg_q[$];    // pc of the instruction writing a register
  logic [57:0] exp_done_q[$];   // {final pc, retired, busy cycles, Ack cycle}

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: event seen, none expected", name);
  endfunction

  // Reference model: walk the program in execution order with plain arithmetic.
  task automatic issue_program();
    int pc_m = 0;
    int ret  = 0;
    int cyc  = 0;
    int sat;
    for (int k = 0; k < prog.size(); k++) begin
      instr_t t = prog[k];
      exp_fetch_q.push_back({10'(pc_m), t.fw});
      cyc += int'(t.fw) + 1;
      cyc += 1;                                   // decode
      if (t.op == HALT) break;
      cyc += 1;                                   // exec
      if (t.rd || t.wr) begin
        exp_mem_q.push_back({t.wr, t.mw});
        cyc += int'(t.mw) + 1;
      end
      if (t.rw && !t.wr) exp_reg_q.push_back(10'(pc_m));
      cyc += 1;                                   // write-back
      ret += 1;
      pc_m = (t.br && t.tk) ? int'(t.tgt) : (pc_m + 1) % 1024;
    end
    sat = (cyc > 65535) ? 65535 : cyc;
    exp_done_q.push_back({10'(pc_m), 16'(ret), 16'(sat), 16'(cyc + 1)});
  endtask

  // ---------------- driver: memory, decoder and Start ----------------
  bit start_req = 0;
  int cur = 0;
  int nxt = 0;
  bit acc_active = 0;
  int wait_left = 0;

  initial begin
    instr_t it;
    Start = 1'b0; mem_ready = 1'b0; opcode = '0;
    dec_mem_read = 1'b0; dec_mem_write = 1'b0; dec_branch = 1'b0;
    dec_reg_write = 1'b0; br_taken = 1'b0; br_target = '0;
    forever begin
      @(posedge Clk); #1;
      if (start_req) begin
        Start = 1'b1;
        start_req = 0;
      end else if (busy === 1'b1) begin
        Start = 1'($urandom_range(0, 1));          // must be ignored while busy
      end else begin
        Start = 1'b0;
      end
      if (mem_req !== 1'b1) begin
        acc_active = 0;
        mem_ready = 1'($urandom_range(0, 1));      // must be ignored outside accesses
      end else begin
        if (!acc_active) begin
          acc_active = 1;
          it = (mem_addr_sel === 1'b1) ? get_instr(cur) : get_instr(nxt);
          wait_left = (mem_addr_sel === 1'b1) ? int'(it.mw) : int'(it.fw);
        end
        if (wait_left > 0) begin
          mem_ready = 1'b0;
          wait_left--;
        end else begin
          mem_ready = 1'b1;
          acc_active = 0;
          if (mem_addr_sel !== 1'b1) begin
            cur = nxt;
            nxt++;
            it = get_instr(cur);
            opcode = it.op; dec_mem_read = it.rd; dec_mem_write = it.wr;
            dec_branch = it.br; br_taken = it.tk; dec_reg_write = it.rw;
            br_target = it.tgt;
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  bit mon_en = 0;

  initial begin
    int run = 0;
    int cyc = 0;
    bit ack_prev = 0;
    bit chk_drop = 0;
    logic [13:0] f;
    logic [4:0]  m;
    logic [9:0]  r;
    logic [57:0] d;
    forever begin
      @(negedge Clk);
      if (!mon_en) begin
        run = 0; chk_drop = 0; ack_prev = (Ack === 1'b1);
        continue;
      end
      if (chk_drop) begin
        check("ack_drop_after_start", {Ack, busy}, 2'b01);
        chk_drop = 0;
      end
      cyc++;
      if (mem_req === 1'b1) run++;
      if (ir_we === 1'b1) begin
        if (exp_fetch_q.size() == 0) flag("fetch_unexpected");
        else begin
          f = exp_fetch_q.pop_front();
          check("fetch_pc", pc, f[13:4]);
          check("fetch_req_cycles", run, int'(f[3:0]) + 1);
          check("fetch_sel_we", {mem_addr_sel, mem_we}, 2'b00);
        end
        run = 0;
      end
      if (mem_req === 1'b1 && mem_addr_sel === 1'b1 && mem_ready === 1'b1) begin
        if (exp_mem_q.size() == 0) flag("mem_unexpected");
        else begin
          m = exp_mem_q.pop_front();
          check("mem_we", mem_we, m[4]);
          check("mem_req_cycles", run, int'(m[3:0]) + 1);
        end
        run = 0;
      end
      if (reg_we === 1'b1) begin
        if (exp_reg_q.size() == 0) flag("reg_we_unexpected");
        else begin
          r = exp_reg_q.pop_front();
          check("reg_we_pc", pc, r);
        end
      end
      if (Ack === 1'b1 && !ack_prev) begin
        if (exp_done_q.size() == 0) flag("ack_unexpected");
        else begin
          d = exp_done_q.pop_front();
          check("done_pc", pc, d[57:48]);
          check("done_instr_count", instr_count, d[47:32]);
          check("done_cycle_count", cycle_count, d[31:16]);
          check("done_ack_cycle", cyc, d[15:0]);
        end
      end
      ack_prev = (Ack === 1'b1);
      if (Start === 1'b1 && busy === 1'b0) begin
        cyc = 0;
        chk_drop = 1;
      end
    end
  end

  // ---------------- test sequence ----------------
  task automatic pulse_reset();
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  task automatic run_program(input string name);
    int c = 0;
    issue_program();
    cur = 0; nxt = 0;
    start_req = 1;
    while (exp_done_q.size() != 0 && c < 3000) begin
      @(negedge Clk);
      c++;
    end
    @(negedge Clk);
    if (exp_done_q.size() != 0) begin
      total++; bad++;
      $display("FAIL %s_timeout: no Ack within %0d cycles", name, c);
      exp_fetch_q.delete(); exp_mem_q.delete(); exp_reg_q.delete(); exp_done_q.delete();
      mon_en = 0;
      pulse_reset();
      @(negedge Clk);
      mon_en = 1;
    end else begin
      check("fetch_left", exp_fetch_q.size(), 0);
      check("mem_left", exp_mem_q.size(), 0);
      check("reg_left", exp_reg_q.size(), 0);
      exp_fetch_q.delete(); exp_mem_q.delete(); exp_reg_q.delete();
    end
  endtask

  task automatic make_random();
    int n = $urandom_range(2, 10);
    instr_t t;
    prog.delete();
    for (int k = 0; k < n; k++) begin
      t.op  = 6'($urandom_range(0, 62));
      t.rd  = 1'($urandom_range(0, 1));
      t.wr  = 1'($urandom_range(0, 1));
      t.br  = 1'($urandom_range(0, 1));
      t.tk  = 1'($urandom_range(0, 1));
      t.rw  = 1'($urandom_range(0, 1));
      t.tgt = 10'($urandom_range(0, 1023));
      t.fw  = 4'($urandom_range(0, 3));
      t.mw  = 4'($urandom_range(0, 3));
      prog.push_back(t);
    end
    prog.push_back(mk(HALT, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
                      4'($urandom_range(0, 3)), 4'd0));
  endtask

  initial begin
    int c;
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    check("reset_pc", pc, 10'd0);
    check("reset_ctrl", {mem_req, mem_we, mem_addr_sel, ir_we, reg_we, busy, Ack}, 7'd0);
    check("reset_cycle_count", cycle_count, 16'd0);
    check("reset_instr_count", instr_count, 16'd0);
    mon_en = 1;

    // ADD then HALT with memory always ready
    prog = '{mk(6'b000001, 0, 0, 0, 0, 1, 10'd0, 4'd0, 4'd0),
             mk(HALT, 0, 0, 0, 0, 0, 10'd0, 4'd0, 4'd0)};
    run_program("add_halt");
    // store flagged as register write: memory write, no register write
    prog = '{mk(6'b000000, 0, 1, 0, 0, 1, 10'd0, 4'd0, 4'd2),
             mk(HALT, 0, 0, 0, 0, 0, 10'd0, 4'd0, 4'd0)};
    run_program("store");
    // fetch held off for three cycles
    prog = '{mk(6'b000001, 0, 0, 0, 0, 1, 10'd0, 4'd3, 4'd0),
             mk(HALT, 0, 0, 0, 0, 0, 10'd0, 4'd0, 4'd0)};
    run_program("fetch_wait");
    // taken branch to 0x02A, then untaken branch falls through
    prog = '{mk(6'b000100, 0, 0, 1, 1, 0, 10'h02A, 4'd0, 4'd0),
             mk(6'b000100, 0, 0, 1, 0, 0, 10'h155, 4'd1, 4'd0),
             mk(HALT, 0, 0, 0, 0, 0, 10'd0, 4'd0, 4'd0)};
    run_program("branch");
    // pc wrap from 0x3FF to 0x000
    prog = '{mk(6'b000100, 0, 0, 1, 1, 0, 10'h3FF, 4'd0, 4'd0),
             mk(6'b000001, 1, 0, 0, 0, 1, 10'd0, 4'd0, 4'd1),
             mk(HALT, 0, 0, 0, 0, 0, 10'd0, 4'd0, 4'd0)};
    run_program("pc_wrap");

    for (int p = 0; p < 20; p++) begin
      make_random();
      run_program("random");
    end

    // reset in the middle of a stalled data access
    mon_en = 0;
    prog = '{mk(6'b000100, 0, 0, 1, 1, 1, 10'h155, 4'd0, 4'd0),
             mk(6'b000000, 0, 1, 0, 0, 1, 10'd0, 4'd0, 4'd15),
             mk(HALT, 0, 0, 0, 0, 0, 10'd0, 4'd0, 4'd0)};
    cur = 0; nxt = 0;
    start_req = 1;
    c = 0;
    while (!(mem_req === 1'b1 && mem_addr_sel === 1'b1) && c < 200) begin
      @(negedge Clk);
      c++;
    end
    check("mem_phase_reached", {mem_req, mem_addr_sel}, 2'b11);
    check("mem_phase_pc", pc, 10'h155);
    pulse_reset();
    @(negedge Clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_pc", pc, 10'd0);
    check("rst_counters", {cycle_count, instr_count}, 32'd0);
    check("rst_outputs", {mem_we, mem_addr_sel, ir_we, reg_we, busy, Ack}, 6'd0);
    mon_en = 1;
    @(negedge Clk);

    prog = '{mk(6'b000001, 0, 0, 0, 0, 1, 10'd0, 4'd0, 4'd0),
             mk(HALT, 0, 0, 0, 0, 0, 10'd0, 4'd0, 4'd0)};
    run_program("after_reset");

    check("final_done_left", exp_done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
